// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch I, load/store D) for a single memory-controller port.
// It grants round-robin on ties, holds the port stable until mem_ready, and aborts hung accesses with a watchdog.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  mem_write,
  output logic [2:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       SIZE_IDLE = 3'b111;
  localparam logic [2:0]       SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t           state, next_state;
  grant_t           last_grant;
  logic [CNT_W-1:0] wd_cnt;
  logic             i_elig, d_elig;
  logic             grant_i, grant_d;
  logic             complete, abort;

  // A requester that just saw its ready pulse is masked for one cycle so its
  // still-held req is not mistaken for a new access.
  assign i_elig = i_req && !i_ready;
  assign d_elig = d_req && !d_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (i_elig && d_elig) begin
          grant_d = (last_grant == GRANT_I);
          grant_i = (last_grant == GRANT_D);
        end else begin
          grant_i = i_elig;
          grant_d = d_elig;
        end
        if (grant_i)      next_state = BUSY_I;
        else if (grant_d) next_state = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wd_cnt == CNT_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_I;
      wd_cnt     <= '0;
      mem_write  <= 1'b0;
      mem_size   <= SIZE_IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      i_ready    <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_ready    <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      i_err   <= 1'b0;
      d_ready <= 1'b0;
      d_err   <= 1'b0;

      if (grant_i) begin
        last_grant <= GRANT_I;
        mem_addr   <= i_addr;
        mem_size   <= SIZE_WORD;
        mem_write  <= 1'b0;
        mem_wdata  <= '0;
      end else if (grant_d) begin
        last_grant <= GRANT_D;
        mem_addr   <= d_addr;
        mem_size   <= d_size;
        mem_write  <= d_we;
        mem_wdata  <= d_wdata;
      end

      if (complete || abort) begin
        wd_cnt    <= '0;
        mem_write <= 1'b0;
        mem_size  <= SIZE_IDLE;
        mem_addr  <= '0;
        mem_wdata <= '0;
        if (state == BUSY_I) begin
          i_ready <= 1'b1;
          i_err   <= abort;
          i_rdata <= complete ? mem_rdata : '0;
        end else begin
          d_ready <= 1'b1;
          d_err   <= abort;
          // A store returns no data; only a completed load captures the bus.
          d_rdata <= (complete && !mem_write) ? mem_rdata : '0;
        end
      end else if (state != IDLE) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the basic grant and alternation flow,
// plus hand-written sequences for store hold, watchdog timeout, the exact-timeout race and reset mid-access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ready, i_err;
  logic [16:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_ready, d_err;
  logic [2:0]  d_size;
  logic [16:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_write, mem_ready;
  logic [2:0]  mem_size;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .mem_write(mem_write), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic [31:0] mrdata;
    logic        mready;
    logic [2:0]  e_size;
    logic [16:0] e_addr;
    logic        e_ir;
    logic [31:0] e_irdata;
    logic        e_dr;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; i_req = 1'b0; i_addr = 17'h00100;
    d_req = 1'b0; d_we = 1'b0; d_size = 3'b010; d_addr = 17'h00200; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;

    // rst ireq dreq mrdata mready | size addr i_ready i_rdata d_ready d_rdata
    add('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'b111, 17'h0,   1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 3'b010, 17'h100, 1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 3'b111, 17'h0,   1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 3'b111, 17'h0,   1'b0, 32'hDEADBEEF, 1'b0, 32'h0});
    add('{1'b0, 1'b0, 1'b0, 32'h11111111, 1'b1, 3'b111, 17'h0,   1'b0, 32'hDEADBEEF, 1'b0, 32'h0});
    add('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'b111, 17'h0,   1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b1, 32'hA0000001, 1'b1, 3'b010, 17'h200, 1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b1, 32'hA0000001, 1'b1, 3'b111, 17'h0,   1'b0, 32'h0,        1'b1, 32'hA0000001});
    add('{1'b0, 1'b1, 1'b1, 32'hB0000002, 1'b1, 3'b010, 17'h100, 1'b0, 32'h0,        1'b0, 32'hA0000001});
    add('{1'b0, 1'b1, 1'b1, 32'hB0000002, 1'b1, 3'b111, 17'h0,   1'b1, 32'hB0000002, 1'b0, 32'hA0000001});
    add('{1'b0, 1'b1, 1'b1, 32'hC0000003, 1'b1, 3'b010, 17'h200, 1'b0, 32'hB0000002, 1'b0, 32'hA0000001});
    add('{1'b0, 1'b1, 1'b1, 32'hC0000003, 1'b1, 3'b111, 17'h0,   1'b0, 32'hB0000002, 1'b1, 32'hC0000003});
    add('{1'b0, 1'b1, 1'b1, 32'hD0000004, 1'b1, 3'b010, 17'h100, 1'b0, 32'hB0000002, 1'b0, 32'hC0000003});
    add('{1'b0, 1'b1, 1'b1, 32'hD0000004, 1'b1, 3'b111, 17'h0,   1'b1, 32'hD0000004, 1'b0, 32'hC0000003});
    add('{1'b0, 1'b0, 1'b0, 32'hD0000004, 1'b1, 3'b111, 17'h0,   1'b0, 32'hD0000004, 1'b0, 32'hC0000003});
    add('{1'b0, 1'b0, 1'b1, 32'hE0000005, 1'b1, 3'b010, 17'h200, 1'b0, 32'hD0000004, 1'b0, 32'hC0000003});
    add('{1'b0, 1'b0, 1'b1, 32'hE0000005, 1'b1, 3'b111, 17'h0,   1'b0, 32'hD0000004, 1'b1, 32'hE0000005});
    add('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'b111, 17'h0,   1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b0, 1'b1, 1'b1, 32'hF0000006, 1'b1, 3'b010, 17'h200, 1'b0, 32'h0,        1'b0, 32'h0});
    add('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'b111, 17'h0,   1'b0, 32'h0,        1'b0, 32'h0});

    #1;
    foreach (tbl[k]) begin
      reset = tbl[k].rst; i_req = tbl[k].ireq; d_req = tbl[k].dreq;
      mem_rdata = tbl[k].mrdata; mem_ready = tbl[k].mready;
      tick();
      check($sformatf("v%0d mem_size", k),  mem_size,  tbl[k].e_size);
      check($sformatf("v%0d mem_addr", k),  mem_addr,  tbl[k].e_addr);
      check($sformatf("v%0d mem_write", k), mem_write, 0);
      check($sformatf("v%0d i_ready", k),   i_ready,   tbl[k].e_ir);
      check($sformatf("v%0d i_rdata", k),   i_rdata,   tbl[k].e_irdata);
      check($sformatf("v%0d d_ready", k),   d_ready,   tbl[k].e_dr);
      check($sformatf("v%0d d_rdata", k),   d_rdata,   tbl[k].e_drdata);
      check($sformatf("v%0d errs", k),      {i_err, d_err}, 0);
    end

    // Store held for 5 busy cycles; requester-side changes must not leak to the port.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 17'h1FFFC; d_wdata = 32'h12345678;
    mem_rdata = 32'hFFFFFFFF; mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("st%0d mem_write", k), mem_write, 1);
      check($sformatf("st%0d mem_addr", k),  mem_addr,  17'h1FFFC);
      check($sformatf("st%0d mem_wdata", k), mem_wdata, 32'h12345678);
      check($sformatf("st%0d mem_size", k),  mem_size,  3'b010);
      check($sformatf("st%0d d_ready", k),   d_ready,   0);
      d_addr = 17'h00AAA; d_wdata = 32'h0; d_we = 1'b0;
      if (k == 4) mem_ready = 1'b1;
      tick();
    end
    check("st d_ready", d_ready, 1);
    check("st d_err", d_err, 0);
    check("st d_rdata", d_rdata, 0);
    check("st mem_write idle", mem_write, 0);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("st d_ready width", d_ready, 0);

    // Good load first so the timeout's zeroing of d_rdata is observable.
    do_reset();
    d_we = 1'b0; d_req = 1'b1; d_addr = 17'h00040; mem_ready = 1'b1; mem_rdata = 32'h5555AAAA;
    tick(); tick();
    check("to pre d_rdata", d_rdata, 32'h5555AAAA);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; mem_ready = 1'b0;
    tick();
    n = 0;
    while (!d_ready && n < 200) begin
      tick();
      n++;
    end
    check("to busy cycles", n, 64);
    check("to d_err", d_err, 1);
    check("to d_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick();
    check("to d_ready width", d_ready, 0);
    check("to d_err width", d_err, 0);
    check("to port idle", mem_size, 3'b111);
    i_req = 1'b1; i_addr = 17'h00300; mem_ready = 1'b1; mem_rdata = 32'h0BADCAFE;
    tick();
    check("after to mem_addr", mem_addr, 17'h00300);
    tick();
    check("after to i_ready", i_ready, 1);
    check("after to i_err", i_err, 0);
    check("after to i_rdata", i_rdata, 32'h0BADCAFE);
    i_req = 1'b0;
    tick();

    // mem_ready arrives on the last permitted busy cycle.
    d_req = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
    tick();
    repeat (63) tick();
    check("xt no early abort", d_ready, 0);
    mem_ready = 1'b1;
    tick();
    check("xt d_ready", d_ready, 1);
    check("xt d_err", d_err, 0);
    check("xt d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Reset in the third busy cycle of a fetch.
    i_req = 1'b1; i_addr = 17'h00100;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("rb mem_size", mem_size, 3'b111);
    check("rb mem_addr", mem_addr, 0);
    check("rb i_ready", i_ready, 0);
    check("rb i_rdata", i_rdata, 0);
    check("rb d_rdata", d_rdata, 0);
    reset = 1'b0; d_req = 1'b1; d_addr = 17'h00200; d_size = 3'b001; mem_ready = 1'b1;
    tick();
    check("rb tie to D addr", mem_addr, 17'h00200);
    check("rb tie to D size", mem_size, 3'b001);
    check("rb no i_ready", i_ready, 0);
    tick();
    check("rb d_ready", d_ready, 1);
    check("rb i_ready still low", i_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-controller port (L1/L2/L3 hierarchy behind it) between two requesters: instruction fetch (I) and load/store data (D).
- Grants one requester at a time with round-robin on ties.
- Latches the winning request and holds it stable on the memory port until the port reports ready.
- Returns read data and a one-cycle ready pulse to the winner, and aborts hung accesses with a watchdog.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 17, byte address width, matching the memory controller.
- TIMEOUT_CYCLES, 64, maximum cycles spent in a busy state before abort; must be >= 2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetch read data.
- i_ready  out  1  one-cycle completion pulse for I.
- i_err  out  1  qualifies i_ready; high means timeout abort.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  3  size code passed through to the memory port.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load read data.
- d_ready  out  1  one-cycle completion pulse for D.
- d_err  out  1  qualifies d_ready; high means timeout abort.
- mem_write  out  1  to controller MemWrite.
- mem_size  out  3  to controller SizeCtr; 3'b111 = no access.
- mem_addr  out  ADDR_WIDTH  to controller addr.
- mem_wdata  out  DATA_WIDTH  to controller WriteData.
- mem_rdata  in  DATA_WIDTH  from controller ReadData.
- mem_ready  in  1  from controller MemReady.

Behaviour:

Reset (any edge with reset=1):
- state=IDLE, last_grant=I.
- mem_write=0, mem_size=3'b111, mem_addr=0, mem_wdata=0.
- i_/d_ ready, err and rdata all 0; watchdog counter=0.
- Reset during BUSY drops the in-flight access. No ready pulse is ever produced for it.

FSM states: IDLE, BUSY_I, BUSY_D.

IDLE:
- Eligible requests are i_req and d_req, each masked by its own ready output in that cycle. This gives a one-cycle bubble so a held req is not re-granted.
- Only one eligible: grant it.
- Both eligible: grant the one that is not last_grant. After reset this means D wins the first tie.
- On grant, register the memory port fields on the same edge. They are driven from registers starting the next cycle.
  - I grant: mem_addr=i_addr, mem_size=3'b010, mem_write=0, mem_wdata=0.
  - D grant: mem_addr=d_addr, mem_size=d_size, mem_write=d_we, mem_wdata=d_wdata.
- Update last_grant on the same edge.
- While in IDLE, the port idles at mem_size=3'b111, mem_write=0.
- mem_ready is ignored in IDLE.

BUSY_x:
- Port fields are frozen. Requester input changes are ignored.
- The watchdog increments every cycle.
- mem_ready=1 on a clock edge:
  - next state IDLE; port returns to idle encoding;
  - x_rdata <= mem_rdata (or 0 for a store);
  - x_ready <= 1, x_err <= 0;
  - counter cleared.
- Counter reaches TIMEOUT_CYCLES-1 with mem_ready=0:
  - next state IDLE;
  - x_ready <= 1, x_err <= 1, x_rdata <= 0;
  - counter cleared.
- mem_ready on the timeout cycle takes precedence: normal completion.

Outputs and latency:
- x_ready and x_err are high for exactly one cycle.
- x_rdata holds its value until that requester's next completion. The other requester's completions do not change it.
- Latency with mem_ready already high at grant: req sampled at edge 0, port driven in cycle 1, mem_ready sampled at edge 1, x_ready high in cycle 2. That is 2 cycles from req to ready.
- Starvation bound: with both requesters continuously requesting, grants strictly alternate I/D.

Test Plan:
- Reset, then i_req=1 with i_addr=0x00100, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_size=3'b010 and mem_addr=0x00100 in cycle 1; i_ready=1, i_err=0, i_rdata=0xDEADBEEF in cycle 2; mem_size back to 3'b111 in cycle 2.
- Both requesting from reset, held continuously, mem_ready=1 -> grant order D,I,D,I.
  - Each ready pulse is 1 cycle wide.
  - One idle cycle (mem_size=3'b111) appears between accesses.
- Store d_we=1, d_size=3'b010, d_addr=0x1FFFC, d_wdata=0x12345678, mem_ready delayed 5 cycles -> mem_write=1 and the address/data are stable for all 5 busy cycles; d_ready one cycle after mem_ready; d_rdata=0.
- mem_ready held 0 with TIMEOUT_CYCLES=64 on a load -> d_ready=1 and d_err=1 after 64 busy cycles; d_rdata=0; port idle afterwards; next request is serviced normally.
- mem_ready asserted on the exact timeout cycle -> normal completion with err=0 and data captured.
- reset asserted in the third busy cycle of an I fetch -> all outputs at reset values next cycle; no i_ready pulse; a subsequent tie is granted to D.
